// File: rtl/leb128_stream_decoder.sv
// LEB128 stream decoder.
//
// unpack_u32 / unpack_i32: combinational unpack datapath. They take a
// five-byte window whose slots after the terminating byte are zero, and
// return the decoded 32-bit value and the encoded length (1..5).
//
// leb128_stream_decoder: collects one encoded value per transaction and
// emits one decoded value per transaction.
//   clk, reset_n         clock, synchronous active-low reset
//   in_data/in_valid     encoded byte stream (bit 7 = continuation)
//   in_ready             decoder accepts a byte this cycle
//   in_signed            decode mode, sampled with the first byte of a value
//   out_data/out_len     decoded value and its encoded length
//   out_signed/out_err   mode used, overlong (5th byte continued) flag
//   out_valid/out_ready  result handshake
// All out_* are zero while out_valid is low.

module unpack_u32 (
  input  logic [7:0]  b0,
  input  logic [7:0]  b1,
  input  logic [7:0]  b2,
  input  logic [7:0]  b3,
  input  logic [7:0]  b4,
  output logic [31:0] value,
  output logic [2:0]  len
);
  // Only the low four payload bits of the fifth byte fit in 32 bits.
  logic unused_bits;
  assign unused_bits = ^b4[7:4];

  always_comb begin
    value = {b4[3:0], b3[6:0], b2[6:0], b1[6:0], b0[6:0]};
    if (!b0[7])      len = 3'd1;
    else if (!b1[7]) len = 3'd2;
    else if (!b2[7]) len = 3'd3;
    else if (!b3[7]) len = 3'd4;
    else             len = 3'd5;
  end
endmodule

module unpack_i32 (
  input  logic [7:0]  b0,
  input  logic [7:0]  b1,
  input  logic [7:0]  b2,
  input  logic [7:0]  b3,
  input  logic [7:0]  b4,
  output logic [31:0] value,
  output logic [2:0]  len
);
  logic [31:0] raw;
  logic        unused_bits;
  assign unused_bits = ^b4[7:4];

  always_comb begin
    raw = {b4[3:0], b3[6:0], b2[6:0], b1[6:0], b0[6:0]};
    if (!b0[7])      len = 3'd1;
    else if (!b1[7]) len = 3'd2;
    else if (!b2[7]) len = 3'd3;
    else if (!b3[7]) len = 3'd4;
    else             len = 3'd5;
    // Sign bit is the top payload bit of the terminating byte; a five-byte
    // value already fills all 32 bits.
    case (len)
      3'd1:    value = {{25{raw[6]}},  raw[6:0]};
      3'd2:    value = {{18{raw[13]}}, raw[13:0]};
      3'd3:    value = {{11{raw[20]}}, raw[20:0]};
      3'd4:    value = {{4{raw[27]}},  raw[27:0]};
      default: value = raw;
    endcase
  end
endmodule

module leb128_stream_decoder (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_signed,
  output logic [31:0] out_data,
  output logic [2:0]  out_len,
  output logic        out_signed,
  output logic        out_err,
  output logic        out_valid,
  input  logic        out_ready
);
  typedef enum logic {COLLECT, EMIT} state_t;

  state_t      state;
  logic [2:0]  cnt;
  logic [7:0]  b0, b1, b2, b3, b4;
  logic        mode;
  logic        err;
  logic        in_ready_q;
  logic        out_valid_q;

  logic [31:0] val_u, val_i;
  logic [2:0]  len_u, len_i;

  unpack_u32 u_unpack_u32 (
    .b0(b0), .b1(b1), .b2(b2), .b3(b3), .b4(b4),
    .value(val_u), .len(len_u)
  );

  unpack_i32 u_unpack_i32 (
    .b0(b0), .b1(b1), .b2(b2), .b3(b3), .b4(b4),
    .value(val_i), .len(len_i)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= COLLECT;
      cnt         <= '0;
      b0          <= '0;
      b1          <= '0;
      b2          <= '0;
      b3          <= '0;
      b4          <= '0;
      mode        <= 1'b0;
      err         <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        COLLECT: begin
          if (in_valid && in_ready_q) begin
            case (cnt)
              3'd0:    b0 <= in_data;
              3'd1:    b1 <= in_data;
              3'd2:    b2 <= in_data;
              3'd3:    b3 <= in_data;
              default: b4 <= in_data;
            endcase
            // Zeroing the tail on the first byte keeps bytes beyond the
            // terminator out of the unpack datapath.
            if (cnt == 3'd0) begin
              b1   <= '0;
              b2   <= '0;
              b3   <= '0;
              b4   <= '0;
              mode <= in_signed;
            end
            if (!in_data[7] || cnt == 3'd4) begin
              state       <= EMIT;
              err         <= (cnt == 3'd4) && in_data[7];
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
            end else begin
              cnt <= cnt + 3'd1;
            end
          end
        end
        EMIT: begin
          if (out_ready) begin
            state       <= COLLECT;
            cnt         <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

  always_comb begin
    in_ready   = in_ready_q;
    out_valid  = out_valid_q;
    out_err    = out_valid_q & err;
    out_signed = out_valid_q & mode;
    out_data   = '0;
    out_len    = '0;
    if (out_valid_q) begin
      if (err) begin
        out_len = 3'd5;
      end else begin
        out_data = mode ? val_i : val_u;
        out_len  = mode ? len_i : len_u;
      end
    end
  end
endmodule

// File: tb/tb_leb128_stream_decoder.sv
// Testbench for leb128_stream_decoder: directed scenarios with known values
// plus randomized values checked against an arithmetic LEB128 model.
module tb_leb128_stream_decoder;
  logic        clk = 1'b0;
  logic        reset_n;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        in_signed;
  logic [31:0] out_data;
  logic [2:0]  out_len;
  logic        out_signed;
  logic        out_err;
  logic        out_valid;
  logic        out_ready;

  int tests = 0;
  int failures = 0;

  leb128_stream_decoder dut (
    .clk(clk), .reset_n(reset_n),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .in_signed(in_signed),
    .out_data(out_data), .out_len(out_len), .out_signed(out_signed),
    .out_err(out_err), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // Expected {valid, err, signed, len, data} for one complete encoded value.
  function automatic logic [37:0] model(input logic [7:0] q[$], input logic sgn);
    longint acc = 0;
    int n = q.size();
    if (n == 5 && q[4][7])
      return {1'b1, 1'b1, sgn, 3'd5, 32'h0};
    for (int i = 0; i < n; i++)
      acc += longint'(q[i] & 8'h7f) << (7 * i);
    if (sgn && q[n-1][6])
      acc -= (longint'(1) << (7 * n));
    return {1'b1, 1'b0, sgn, 3'(n), acc[31:0]};
  endfunction

  // Present one byte and return just after the edge that accepts it.
  task automatic send_byte(input logic [7:0] b, input logic sgn);
    int unsigned guard = 0;
    in_data = b;
    in_signed = sgn;
    in_valid = 1'b1;
    while (in_ready !== 1'b1 && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    if (in_ready !== 1'b1) begin
      $display("FAIL send_timeout: in_ready=%b required 1", in_ready);
      tests++; failures++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic retire();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; in_valid = 1'b0; in_data = '0; in_signed = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if ({in_ready, out_valid, out_err, out_signed, out_len, out_data} !== {1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 32'd0}) begin
      $display("FAIL reset_state: got rdy=%b vld=%b err=%b sg=%b len=%0d data=%h required rdy=1 all out 0",
               in_ready, out_valid, out_err, out_signed, out_len, out_data);
      failures++;
    end
    reset_n = 1'b1;
  endtask

  task automatic test_unsigned_single();
    send_byte(8'h02, 1'b0);
    tests++;
    if ({out_valid, out_err, out_signed, out_len, out_data} !== {1'b1, 1'b0, 1'b0, 3'd1, 32'h2}) begin
      $display("FAIL unsigned_single: got %h required %h",
               {out_valid, out_err, out_signed, out_len, out_data}, {1'b1, 1'b0, 1'b0, 3'd1, 32'h2});
      failures++;
    end
    retire();
    tests++;
    if ({in_ready, out_valid} !== 2'b10) begin
      $display("FAIL retire_ready: got rdy=%b vld=%b required rdy=1 vld=0", in_ready, out_valid);
      failures++;
    end
  endtask

  task automatic test_signed_single();
    send_byte(8'h7F, 1'b1);
    tests++;
    if ({out_valid, out_err, out_signed, out_len, out_data} !== {1'b1, 1'b0, 1'b1, 3'd1, 32'hFFFFFFFF}) begin
      $display("FAIL signed_single: got %h required %h",
               {out_valid, out_err, out_signed, out_len, out_data}, {1'b1, 1'b0, 1'b1, 3'd1, 32'hFFFFFFFF});
      failures++;
    end
    retire();
    send_byte(8'h7F, 1'b0);
    tests++;
    if ({out_valid, out_err, out_signed, out_len, out_data} !== {1'b1, 1'b0, 1'b0, 3'd1, 32'h7F}) begin
      $display("FAIL unsigned_7f: got %h required %h",
               {out_valid, out_err, out_signed, out_len, out_data}, {1'b1, 1'b0, 1'b0, 3'd1, 32'h7F});
      failures++;
    end
    retire();
  endtask

  task automatic test_multi_backpressure();
    logic [37:0] exp_a = {1'b1, 1'b0, 1'b0, 3'd3, 32'h00098765};
    logic [37:0] exp_b = {1'b1, 1'b0, 1'b1, 3'd3, 32'hFFFE1DC0};
    send_byte(8'hE5, 1'b0);
    send_byte(8'h8E, 1'b0);
    send_byte(8'h26, 1'b0);
    tests++;
    if ({out_valid, out_err, out_signed, out_len, out_data} !== exp_a) begin
      $display("FAIL multi_unsigned: got %h required %h", {out_valid, out_err, out_signed, out_len, out_data}, exp_a);
      failures++;
    end
    // Offered bytes during EMIT must be ignored and outputs held.
    in_valid = 1'b1; in_data = 8'h11; in_signed = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      tests++;
      if ({in_ready, out_valid, out_err, out_signed, out_len, out_data} !== {1'b0, exp_a}) begin
        $display("FAIL hold_cycle%0d: got rdy=%b out=%h required rdy=0 out=%h", i, in_ready,
                 {out_valid, out_err, out_signed, out_len, out_data}, exp_a);
        failures++;
      end
    end
    in_valid = 1'b0;
    retire();
    send_byte(8'hC0, 1'b1);
    send_byte(8'hBB, 1'b1);
    send_byte(8'h78, 1'b1);
    tests++;
    if ({out_valid, out_err, out_signed, out_len, out_data} !== exp_b) begin
      $display("FAIL multi_signed: got %h required %h", {out_valid, out_err, out_signed, out_len, out_data}, exp_b);
      failures++;
    end
    retire();
  endtask

  task automatic test_five_byte();
    logic [37:0] exp_max  = {1'b1, 1'b0, 1'b0, 3'd5, 32'hFFFFFFFF};
    logic [37:0] exp_err  = {1'b1, 1'b1, 1'b0, 3'd5, 32'h0};
    logic [37:0] exp_next = {1'b1, 1'b0, 1'b0, 3'd1, 32'h5};
    for (int i = 0; i < 4; i++) send_byte(8'hFF, 1'b0);
    send_byte(8'h0F, 1'b0);
    tests++;
    if ({out_valid, out_err, out_signed, out_len, out_data} !== exp_max) begin
      $display("FAIL five_max: got %h required %h", {out_valid, out_err, out_signed, out_len, out_data}, exp_max);
      failures++;
    end
    retire();
    for (int i = 0; i < 5; i++) send_byte(8'h80, 1'b0);
    tests++;
    if ({out_valid, out_err, out_signed, out_len, out_data} !== exp_err) begin
      $display("FAIL overlong: got %h required %h", {out_valid, out_err, out_signed, out_len, out_data}, exp_err);
      failures++;
    end
    retire();
    send_byte(8'h05, 1'b0);
    tests++;
    if ({out_valid, out_err, out_signed, out_len, out_data} !== exp_next) begin
      $display("FAIL after_overlong: got %h required %h", {out_valid, out_err, out_signed, out_len, out_data}, exp_next);
      failures++;
    end
    retire();
  endtask

  task automatic test_bubbles();
    logic [37:0] exp_a = {1'b1, 1'b0, 1'b0, 3'd3, 32'h00098765};
    send_byte(8'hE5, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    send_byte(8'h8E, 1'b1);
    @(posedge clk); #1;
    send_byte(8'h26, 1'b1);
    tests++;
    if ({out_valid, out_err, out_signed, out_len, out_data} !== exp_a) begin
      $display("FAIL bubbles: got %h required %h", {out_valid, out_err, out_signed, out_len, out_data}, exp_a);
      failures++;
    end
    retire();
  endtask

  task automatic test_reset_mid();
    logic [37:0] exp_26 = {1'b1, 1'b0, 1'b0, 3'd1, 32'h26};
    send_byte(8'hE5, 1'b0);
    send_byte(8'h8E, 1'b0);
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    tests++;
    if ({in_ready, out_valid} !== 2'b10) begin
      $display("FAIL reset_mid_collect: got rdy=%b vld=%b required rdy=1 vld=0", in_ready, out_valid);
      failures++;
    end
    send_byte(8'h26, 1'b0);
    tests++;
    if ({out_valid, out_err, out_signed, out_len, out_data} !== exp_26) begin
      $display("FAIL after_reset: got %h required %h", {out_valid, out_err, out_signed, out_len, out_data}, exp_26);
      failures++;
    end
    out_ready = 1'b0;
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    tests++;
    if ({in_ready, out_valid, out_err, out_signed, out_len, out_data} !== {1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 32'd0}) begin
      $display("FAIL reset_in_emit: got rdy=%b vld=%b len=%0d data=%h required rdy=1 vld=0 len=0 data=0",
               in_ready, out_valid, out_len, out_data);
      failures++;
    end
  endtask

  task automatic test_random();
    for (int v = 0; v < 40; v++) begin
      logic [7:0]  q[$];
      logic        sgn;
      logic [37:0] exp;
      int          n;
      q = {};
      n = $urandom_range(1, 5);
      sgn = 1'($urandom_range(0, 1));
      for (int i = 0; i < n; i++) begin
        logic [7:0] b;
        b = 8'($urandom);
        if (i < n - 1) b[7] = 1'b1;
        else if (n < 5) b[7] = 1'b0;
        q.push_back(b);
      end
      exp = model(q, sgn);
      for (int i = 0; i < n; i++) begin
        // Mode must come from the first byte only.
        send_byte(q[i], (i == 0) ? sgn : 1'($urandom_range(0, 1)));
        if (i < n - 1 && $urandom_range(0, 3) == 0) begin
          @(posedge clk); #1;
        end
      end
      tests++;
      if ({out_valid, out_err, out_signed, out_len, out_data} !== exp) begin
        $display("FAIL random%0d: got %h required %h", v, {out_valid, out_err, out_signed, out_len, out_data}, exp);
        failures++;
      end
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      tests++;
      if ({in_ready, out_valid, out_err, out_signed, out_len, out_data} !== {1'b0, exp}) begin
        $display("FAIL random_hold%0d: got rdy=%b out=%h required rdy=0 out=%h", v, in_ready,
                 {out_valid, out_err, out_signed, out_len, out_data}, exp);
        failures++;
      end
      retire();
    end
  endtask

  initial begin
    test_reset();
    test_unsigned_single();
    test_signed_single();
    test_multi_backpressure();
    test_five_byte();
    test_bubbles();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end
endmodule
